lsu: RTL
========

# lsu

Load/store unit placed directly downstream of the execute ALU. It takes the effective address computed for load/store instructions plus the store operand, runs one data-memory transaction over a valid/ready request channel, and returns a lane-aligned, sign- or zero-extended load result for writeback. One transaction is in flight at a time; the core stalls on `busy`.

## Interface
Parameters: none (address and data fixed at 32 bits).

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request pulse; accepted only in IDLE
- `is_load`  in  1  transaction is a load (sampled with `start`)
- `is_store`  in  1  transaction is a store (sampled with `start`)
- `funct3`  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU load-only)
- `address`  in  32  effective byte address from the ALU
- `store_data`  in  32  rs2 value; low byte/half/word used
- `busy`  out  1  high from the cycle after accept until `done`
- `done`  out  1  one-cycle completion pulse
- `fault`  out  1  valid with `done`; misaligned or illegal request, no memory access made
- `load_result`  out  32  extended load data; updated only on a successful load `done`
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  1 = write
- `mem_addr`  out  32  word-aligned address ({address[31:2], 2'b00})
- `mem_wstrb`  out  4  byte enables (writes); 4'b1111 on reads
- `mem_wdata`  out  32  lane-replicated store data
- `mem_rdata`  in  32  read data, valid when `mem_ready` is high on a read
- `mem_ready`  in  1  memory accepts/completes the request this cycle

## Operation
- States: IDLE, REQ, RESP.
- IDLE: on `start`, register address, funct3, kind, store data. Legal → REQ; illegal → RESP with fault flag set.
- Illegal: misaligned H/HU (addr[0]≠0), misaligned W (addr[1:0]≠0), funct3 ∈ {011,110,111}, BU/HU with store, both or neither of is_load/is_store.
- REQ: `mem_req`=1, all mem_* outputs stable until `mem_ready`. On `mem_ready` → RESP; for loads capture `mem_rdata` the same edge.
- RESP: `done`=1 for one cycle, `fault` per flag, → IDLE.
- Store lanes: B: wdata = {4{d[7:0]}}, wstrb = 4'b0001 << addr[1:0]; H: wdata = {2{d[15:0]}}, wstrb = 4'b0011 << addr[1:0]; W: wdata = d, wstrb = 4'b1111.
- Load extract: byte = rdata >> (8*addr[1:0]), half = rdata >> (16*addr[1]); B/H sign-extend, BU/HU zero-extend, W pass-through.
- `start` while not IDLE: ignored, no effect on the current transaction.
- Store or faulting `done`: `load_result` retains its previous value.

## Timing
- Reset values: `busy`, `done`, `fault`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wstrb`, `mem_wdata`, `load_result` = 0; state IDLE.
- All outputs registered or decoded from state only; no combinational path from `start` or `mem_ready` to any output.
- Accept at edge N → `mem_req` high in cycle N+1. `mem_ready` high in cycle N+1+k → `done` in cycle N+2+k. Zero-wait latency: `done` 2 cycles after `start`.
- Fault path: `done`+`fault` in cycle N+1, `mem_req` never asserted.
- Next `start` may be presented in the cycle `done` is high (accepted when the FSM is in IDLE the following cycle).
- `rst` asserted mid-transaction: `mem_req` and `busy` drop immediately (asynchronously); no `done` is produced for the aborted access.

## Structure
- Package `lsu_pkg`: funct3 localparams (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU) and the state enum.
- Sub-module `lsu_align`: purely combinational; store lane steering (wdata/wstrb) and load extract/extend. The FSM lives in `lsu`.

## Test plan
- SB addr 0x1003, data 0xAABBCCDD, ready immediately → wstrb 4'b1000, wdata 0xDDDDDDDD, mem_addr 0x1000, done 2 cycles after start, fault 0.
- LB addr 0x2001, rdata 0x0000_80FF after 3 wait cycles → load_result 0xFFFFFF80, done 5 cycles after start; LBU same → 0x00000080.
- LH addr 0x2002, rdata 0x8001_1234 → 0xFFFF8001; LW addr 0x2000 → 0x80011234.
- LW addr 0x2002 → done+fault the next cycle, mem_req never high, load_result unchanged.
- `start` pulsed while REQ is stalling → ignored, the original transaction completes with its own address; `rst` during REQ → mem_req drops at once, no done.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 size/sign encodings (LSU_B .. LSU_HU)
//   - FSM state enum
//   - lsu_legal(): decides whether a request may touch memory
package lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Exactly one of load/store, a defined size code, no unsigned stores,
  // and natural alignment for halves and words.
  function automatic logic lsu_legal(input logic [2:0] f3,
                                     input logic [1:0] addr_lo,
                                     input logic       ld,
                                     input logic       st);
    logic ok;
    ok = ld ^ st;
    case (f3)
      LSU_B:   ok = ok;
      LSU_H:   ok = ok & ~addr_lo[0];
      LSU_W:   ok = ok & (addr_lo == 2'b00);
      LSU_BU:  ok = ok & ~st;
      LSU_HU:  ok = ok & ~st & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   Store side (from the request being accepted):
//     st_funct3, st_addr_lo, st_data -> st_wdata (lane-replicated), st_wstrb
//   Load side (from the registered request and memory read data):
//     ld_funct3, ld_addr_lo, ld_rdata -> ld_result (extracted, extended)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic [31:0] ld_result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store steering: replicate the operand into every lane, enable only the target bytes.
  always_comb begin
    st_wdata = st_data;
    st_wstrb = 4'b0000;
    case (st_funct3)
      LSU_B: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstrb = 4'b0001 << st_addr_lo;
      end
      LSU_H: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstrb = 4'b0011 << st_addr_lo;
      end
      LSU_W: begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
      end
      default: begin
        st_wdata = st_data;
        st_wstrb = 4'b0000;
      end
    endcase
  end

  // Load extract: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    byte_s    = 8'(ld_rdata >> {ld_addr_lo, 3'b000});
    half_s    = 16'(ld_rdata >> {ld_addr_lo[1], 4'b0000});
    ld_result = ld_rdata;
    case (ld_funct3)
      LSU_B:   ld_result = {{24{byte_s[7]}}, byte_s};
      LSU_H:   ld_result = {{16{half_s[15]}}, half_s};
      LSU_W:   ld_result = ld_rdata;
      LSU_BU:  ld_result = {24'h000000, byte_s};
      LSU_HU:  ld_result = {16'h0000, half_s};
      default: ld_result = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit.
//   Core side : start, is_load, is_store, funct3, address, store_data in;
//               busy, done, fault, load_result out.
//   Memory    : mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata out;
//               mem_rdata, mem_ready in.
// All outputs come from registers or from the state register alone, so
// start and mem_ready never reach an output combinationally.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  lsu_state_e  state_r, state_s;
  logic [31:0] addr_r;
  logic [2:0]  funct3_r;
  logic        is_load_r;
  logic        we_r;
  logic        fault_r;
  logic [3:0]  wstrb_r;
  logic [31:0] wdata_r;
  logic [31:0] load_result_r;

  logic        legal_s;
  logic        accept_s;
  logic        capture_s;
  logic [31:0] st_wdata_s;
  logic [3:0]  st_wstrb_s;
  logic [31:0] ld_result_s;

  assign legal_s = lsu_legal(funct3, address[1:0], is_load, is_store);

  lsu_align u_align (
    .st_funct3  (funct3),
    .st_addr_lo (address[1:0]),
    .st_data    (store_data),
    .ld_funct3  (funct3_r),
    .ld_addr_lo (addr_r[1:0]),
    .ld_rdata   (mem_rdata),
    .st_wdata   (st_wdata_s),
    .st_wstrb   (st_wstrb_s),
    .ld_result  (ld_result_s)
  );

  // Next-state logic; also flags the accept and load-capture edges.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = legal_s ? ST_REQ : ST_RESP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_s   = ST_RESP;
          capture_s = is_load_r;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register; async reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture at accept and load-data capture on the ready edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r        <= 32'h0000_0000;
      funct3_r      <= 3'b000;
      is_load_r     <= 1'b0;
      we_r          <= 1'b0;
      fault_r       <= 1'b0;
      wstrb_r       <= 4'b0000;
      wdata_r       <= 32'h0000_0000;
      load_result_r <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        addr_r    <= address;
        funct3_r  <= funct3;
        is_load_r <= is_load;
        we_r      <= is_store;
        fault_r   <= ~legal_s;
        // Reads always enable the full word; lane selection happens on return.
        wstrb_r   <= is_load ? 4'b1111 : st_wstrb_s;
        wdata_r   <= st_wdata_s;
      end
      if (capture_s) begin
        load_result_r <= ld_result_s;
      end
    end
  end

  assign busy        = (state_r != ST_IDLE);
  assign done        = (state_r == ST_RESP);
  assign fault       = (state_r == ST_RESP) & fault_r;
  assign mem_req     = (state_r == ST_REQ);
  assign mem_we      = we_r;
  assign mem_addr    = {addr_r[31:2], 2'b00};
  assign mem_wstrb   = wstrb_r;
  assign mem_wdata   = wdata_r;
  assign load_result = load_result_r;

endmodule
